// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// All outputs decode directly from registers, so out_ready never reaches in_ready combinationally.
module pipe_skid_stage #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    // bit0 is the main valid bit, bit1 the skid valid bit
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              accept, fire;

    assign out_valid = state_q[0];
    assign in_ready  = !state_q[1];
    assign occupancy = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    state_d = accept ? ONE : EMPTY;
                    main_d  = accept ? in_data : main_q;
                end
                ONE: begin
                    if (accept && fire) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                FULL: begin
                    state_d = fire ? ONE : FULL;
                    main_d  = fire ? skid_q : main_q;
                    skid_d  = fire ? BUBBLE : skid_q;
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks of pipe_skid_stage against a reference FIFO scoreboard.
module tb_pipe_skid_stage;
    logic        clk = 0;
    logic        rst, flush;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [63:0] qa[$];
    logic [31:0] qb[$];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(64), .BUBBLE(64'h0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_skid_stage #(.DATA_W(32), .BUBBLE(32'h13)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference FIFOs: pop on every fire, drop everything on flush/reset, push on accept.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL a_sb_extra: got %0h expected nothing (queue empty)", a_out_data);
                end else chk("a_sb", a_out_data, qa.pop_front());
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL b_sb_extra: got %0h expected nothing (queue empty)", b_out_data);
                end else chk("b_sb", {32'h0, b_out_data}, {32'h0, qb.pop_front()});
            end
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
                if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
            end
        end
    end

    task automatic drive_a(input logic v, input logic [63:0] d, input logic r);
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = r;
    endtask

    initial begin
        int sent;
        int cycles;
        rst = 1; flush = 0;
        drive_a(0, 0, 0);
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        #1;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_ready", a_in_ready, 1);
        chk("rst_a_occ", a_occ, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_b_data", b_out_data, 64'h13);
        step(); step();
        rst = 0;
        // streaming
        for (int i = 1; i <= 4; i++) begin
            drive_a(1, 64'(i), 1);
            step();
            chk("stream_occ", a_occ, 1);
            chk("stream_ready", a_in_ready, 1);
            chk("stream_data", a_out_data, 64'(i));
        end
        drive_a(0, 0, 1);
        step();
        chk("drain_valid", a_out_valid, 0);
        chk("drain_data", a_out_data, 0);
        // stall and skid
        drive_a(1, 64'h10, 1);
        step();
        chk("skid_head", a_out_data, 64'h10);
        drive_a(1, 64'h11, 0);
        step();
        chk("skid_occ2", a_occ, 2);
        chk("skid_ready0", a_in_ready, 0);
        chk("skid_head_hold", a_out_data, 64'h10);
        drive_a(1, 64'h12, 0);
        step();
        chk("skid_stable", a_out_data, 64'h10);
        chk("skid_occ_hold", a_occ, 2);
        drive_a(1, 64'h12, 1);
        step();
        chk("release_data", a_out_data, 64'h11);
        chk("release_ready", a_in_ready, 1);
        chk("release_occ", a_occ, 1);
        step();
        chk("release_next", a_out_data, 64'h12);
        drive_a(0, 0, 1);
        step();
        chk("release_empty", a_occ, 0);
        // flush while FULL
        drive_a(1, 64'h20, 0);
        step();
        drive_a(1, 64'h21, 0);
        step();
        chk("ffull_occ2", a_occ, 2);
        flush = 1;
        drive_a(1, 64'h22, 0);
        step();
        flush = 0;
        chk("ffull_occ", a_occ, 0);
        chk("ffull_valid", a_out_valid, 0);
        chk("ffull_data", a_out_data, 0);
        chk("ffull_ready", a_in_ready, 1);
        drive_a(0, 0, 1);
        step(); step();
        chk("ffull_no22", a_out_valid, 0);
        // flush in ONE with fire and a discarded accept
        drive_a(1, 64'h30, 1);
        step();
        chk("fone_head", a_out_data, 64'h30);
        flush = 1;
        drive_a(1, 64'h31, 1);
        step();
        flush = 0;
        chk("fone_occ", a_occ, 0);
        drive_a(1, 64'h40, 1);
        step();
        chk("fone_next_valid", a_out_valid, 1);
        chk("fone_next_data", a_out_data, 64'h40);
        drive_a(0, 0, 1);
        step();
        // asynchronous reset while FULL
        drive_a(1, 64'h50, 0);
        step();
        drive_a(1, 64'h51, 0);
        step();
        drive_a(0, 0, 0);
        chk("arst_pre_occ", a_occ, 2);
        #2 rst = 1;
        #1;
        chk("arst_valid", a_out_valid, 0);
        chk("arst_ready", a_in_ready, 1);
        chk("arst_occ", a_occ, 0);
        chk("arst_data", a_out_data, 0);
        step();
        rst = 0;
        chk("a_queue_left", 64'(qa.size()), 0);
        // BUBBLE = 0x13 instance: drain and flush
        b_in_valid = 1; b_in_data = 32'h5; b_out_ready = 0;
        step();
        chk("b_head", {32'h0, b_out_data}, 64'h5);
        b_in_valid = 0; b_out_ready = 1;
        step();
        chk("b_drain_valid", b_out_valid, 0);
        chk("b_drain_bubble", {32'h0, b_out_data}, 64'h13);
        b_in_valid = 1; b_in_data = 32'h6; b_out_ready = 0;
        step();
        b_in_valid = 0;
        flush = 1;
        step();
        flush = 0;
        chk("b_flush_bubble", {32'h0, b_out_data}, 64'h13);
        chk("b_flush_occ", b_occ, 0);
        // random traffic
        sent = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 40000) begin
            b_in_valid  = $urandom_range(0, 3) != 0;
            b_in_data   = $urandom;
            b_out_ready = $urandom_range(0, 2) != 0;
            if (b_in_valid && b_in_ready) sent++;
            cycles++;
            step();
        end
        chk("b_rand_sent", 64'(sent), 10000);
        b_in_valid = 0; b_out_ready = 1;
        step(); step(); step();
        chk("b_rand_drained", 64'(qb.size()), 0);
        chk("b_rand_empty_bubble", {32'h0, b_out_data}, 64'h13);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
